sub_32bit_pipe: RTL and testbench

Two-stage pipelined 32-bit unsigned/two's-complement subtractor with valid/ready handshakes on both sides. It computes `diff = a - b` and the borrow, signed-overflow and zero flags. It sits in the datapath as the inverse operator alongside the combinational 32-bit carry-lookahead adder. The 32-bit borrow chain is split across two register stages so the subtractor closes timing at higher clock rates than the single-cycle adder.

---
 rtl/sub_32bit_pipe.sv | 132 +++++++++++++
 tb/tb_sub_32bit_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sub_32bit_pipe.sv
// sub_32bit_pipe
//
// Two-stage pipelined subtractor: diff = a - b computed as a + ~b + 1, with
// the borrow chain split at WIDTH/2 so each stage carries only half the word.
// S1 registers the low-half sum, its carry-out and the high-half operands.
// S2 finishes the high half, registers the full difference and derives the
// borrow / signed-overflow / zero flags.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, flushes both stages
//   in_valid   in   operand pair presented
//   in_ready   out  operand pair accepted this cycle (no path from in_valid)
//   a, b       in   minuend, subtrahend (WIDTH bits)
//   out_valid  out  result presented
//   out_ready  in   consumer takes the result this cycle
//   diff       out  (a - b) mod 2^WIDTH
//   borrow     out  a < b unsigned
//   ovf        out  signed overflow of a - b
//   zero       out  diff == 0
//
// WIDTH must be even.

module sub_32bit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int H  = WIDTH / 2;
    localparam int HI = WIDTH - H;

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;
    logic s1_load;
    logic s2_load;

    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        // rst_n gates ready so nothing appears accepted while reset is held.
        in_ready = rst_n && s1_adv;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_valid && s2_adv;
    end

    // ---------------- stage 1: low half ----------------
    logic [H:0]    lo_sum;
    logic [H-1:0]  s1_lo;
    logic          s1_c_mid;
    logic [HI-1:0] s1_a_hi;
    logic [HI-1:0] s1_nb_hi;

    always_comb begin
        // +1 of the two's-complement negate enters as the low-half carry-in.
        lo_sum = {1'b0, a[H-1:0]} + {1'b0, ~b[H-1:0]} + {{H{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c_mid <= 1'b0;
            s1_a_hi  <= '0;
            s1_nb_hi <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_sum[H-1:0];
                s1_c_mid <= lo_sum[H];
                s1_a_hi  <= a[WIDTH-1:H];
                s1_nb_hi <= ~b[WIDTH-1:H];
            end else if (s2_load) begin
                // S1 emptied into S2 with nothing new behind it.
                s1_valid <= 1'b0;
            end
        end
    end

    // ---------------- stage 2: high half + flags ----------------
    logic [HI:0]    hi_sum;
    logic [WIDTH-1:0] diff_nxt;
    logic           borrow_nxt;
    logic           ovf_nxt;
    logic           zero_nxt;
    logic           a_msb;
    logic           b_msb;

    always_comb begin
        hi_sum     = {1'b0, s1_a_hi} + {1'b0, s1_nb_hi} + {{HI{1'b0}}, s1_c_mid};
        diff_nxt   = {hi_sum[HI-1:0], s1_lo};
        borrow_nxt = ~hi_sum[HI];
        a_msb      = s1_a_hi[HI-1];
        b_msb      = ~s1_nb_hi[HI-1];
        ovf_nxt    = (a_msb != b_msb) && (diff_nxt[WIDTH-1] != a_msb);
        zero_nxt   = (diff_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                diff      <= diff_nxt;
                borrow    <= borrow_nxt;
                ovf       <= ovf_nxt;
                zero      <= zero_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// Directed bench for sub_32bit_pipe: reset values, arithmetic vectors with
// hand-computed results, back-to-back streaming, backpressure, mid-run reset.

module tb_sub_32bit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;

    int n_vec;
    int n_err;

    sub_32bit_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // hand-computed vectors: a, b, diff, borrow, ovf, zero
    localparam int NV = 8;
    logic [31:0] va [NV] = '{32'd5, 32'h12345678, 32'h0, 32'h00010000,
                             32'h80000000, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h00000003};
    logic [31:0] vb [NV] = '{32'd3, 32'h12345678, 32'h1, 32'h00000001,
                             32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h00000005};
    logic [31:0] vd [NV] = '{32'd2, 32'h0, 32'hFFFFFFFF, 32'h0000FFFF,
                             32'h7FFFFFFF, 32'h80000000, 32'hDEADBEEF, 32'hFFFFFFFE};
    logic        vbr [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vov [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vze [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk_result(input string tag, input int i);
        chk({tag, "_valid"},  32'(out_valid), 32'd1);
        chk({tag, "_diff"},   diff,           vd[i]);
        chk({tag, "_borrow"}, 32'(borrow),    32'(vbr[i]));
        chk({tag, "_ovf"},    32'(ovf),       32'(vov[i]));
        chk({tag, "_zero"},   32'(zero),      32'(vze[i]));
    endtask

    // single pair through an empty pipe with out_ready=1, latency 2
    task automatic run_vec(input int i, input string tag);
        @(negedge clk);
        a = va[i]; b = vb[i]; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_result(tag, i);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = va[0]; b = vb[0];

        // 1. reset values with in_valid held high
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      diff,           32'd0);
        chk("rst_flags",     {29'd0, borrow, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);                       // first edge accepted (5,3)
        in_valid = 1'b0;
        chk("rel_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_result("basic", 0);

        // 2-4. arithmetic and boundary vectors one at a time
        run_vec(1, "equal");
        run_vec(2, "borrow");
        run_vec(3, "xstage");
        run_vec(4, "ovf_pos");
        run_vec(5, "ovf_neg");
        run_vec(6, "b_zero");
        run_vec(7, "small_neg");

        // streaming: one pair per cycle, one result per cycle
        @(negedge clk);
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                a = va[i]; b = vb[i]; in_valid = 1'b1;
                chk($sformatf("strm_rdy%0d", i), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (i >= 2) chk_result($sformatf("strm%0d", i - 2), i - 2);
            @(negedge clk);
        end
        chk("strm_drained", 32'(out_valid), 32'd0);

        // 5. backpressure
        out_ready = 1'b0;
        a = 32'd10; b = 32'd1; in_valid = 1'b1;
        chk("bp_rdy0", 32'(in_ready), 32'd1);
        @(negedge clk);
        a = 32'd20; b = 32'd2;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(negedge clk);
        a = 32'd30; b = 32'd3;
        chk("bp_full_rdy", 32'(in_ready),  32'd0);
        chk("bp_full_val", 32'(out_valid), 32'd1);
        chk("bp_full_d",   diff,           32'd9);
        @(negedge clk);
        chk("bp_hold_rdy", 32'(in_ready),  32'd0);
        chk("bp_hold_d",   diff,           32'd9);
        chk("bp_hold_val", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);                       // 9 taken, (30,3) accepted
        in_valid = 1'b0;
        chk("bp_d18", diff, 32'd18);
        chk("bp_v18", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_d27", diff, 32'd27);
        chk("bp_v27", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // 6. reset mid-operation with two results in flight
        out_ready = 1'b0;
        a = 32'd4; b = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        a = 32'd6; b = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_full", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_diff",      diff,           32'd0);
        chk("mr_in_ready",  32'(in_ready),  32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("mr_no_stale", 32'(out_valid), 32'd0);
        end
        run_vec(1, "mr_equal");
        @(negedge clk);
        // (7,7) as a fresh pair after the flush
        a = 32'd7; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr77_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("mr77_valid", 32'(out_valid), 32'd1);
        chk("mr77_zero",  32'(zero),      32'd1);
        chk("mr77_diff",  diff,           32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
